// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle MIPS datapath: PC source selects, exception causes,
// default handler-byte vectors and the exception-entry FSM state type.
package cpu_pkg;

  localparam logic [2:0] PC_SRC_ALU  = 3'd0;
  localparam logic [2:0] PC_SRC_BR   = 3'd1;
  localparam logic [2:0] PC_SRC_JUMP = 3'd2;
  localparam logic [2:0] PC_SRC_RS   = 3'd3;
  localparam logic [2:0] PC_SRC_EPC  = 3'd4;

  localparam logic [1:0] EXC_NONE = 2'd0;
  localparam logic [1:0] EXC_OPC  = 2'd1;
  localparam logic [1:0] EXC_OVF  = 2'd2;
  localparam logic [1:0] EXC_DIV0 = 2'd3;

  localparam logic [31:0] VEC_OPC_DEFAULT  = 32'd253;
  localparam logic [31:0] VEC_OVF_DEFAULT  = 32'd254;
  localparam logic [31:0] VEC_DIV0_DEFAULT = 32'd255;

  typedef enum logic [1:0] {
    StIdle,
    StExcReq,
    StExcWait,
    StExcLoad
  } exc_state_t;

  // Fixed priority: invalid opcode, then overflow, then divide by zero.
  function automatic logic [1:0] exc_cause(input logic opc, input logic ovf, input logic div0);
    if (opc) begin
      return EXC_OPC;
    end else if (ovf) begin
      return EXC_OVF;
    end else if (div0) begin
      return EXC_DIV0;
    end
    return EXC_NONE;
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC source selector. Codes above PC_SRC_EPC are reserved and flagged so the caller
// can suppress the load.
module pc_next_mux
  import cpu_pkg::*;
(
  input  logic [2:0]  pc_src_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] alu_out_i,
  input  logic [31:0] jump_target_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] epc_i,
  output logic [31:0] pc_next_o,
  output logic        reserved_o
);

  always_comb begin
    pc_next_o  = '0;
    reserved_o = 1'b0;
    case (pc_src_i)
      PC_SRC_ALU:  pc_next_o = alu_result_i;
      PC_SRC_BR:   pc_next_o = alu_out_i;
      PC_SRC_JUMP: pc_next_o = jump_target_i;
      PC_SRC_RS:   pc_next_o = rs_data_i;
      PC_SRC_EPC:  pc_next_o = epc_i;
      default:     reserved_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/pc_next_unit.sv
// PC/EPC registers, next-PC selection and the exception-entry sequencer that fetches the
// handler byte from memory and loads it into the PC.
module pc_next_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MEM_LAT  = 2,
  parameter logic [31:0] VEC_OPC  = VEC_OPC_DEFAULT,
  parameter logic [31:0] VEC_OVF  = VEC_OVF_DEFAULT,
  parameter logic [31:0] VEC_DIV0 = VEC_DIV0_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_write,
  input  logic        pc_write_cond,
  input  logic        cond_met,
  input  logic [2:0]  pc_src,
  input  logic [31:0] alu_result,
  input  logic [31:0] alu_out,
  input  logic [31:0] jump_target,
  input  logic [31:0] rs_data,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_div0,
  input  logic [7:0]  mem_byte,
  output logic [31:0] pc_out,
  output logic [31:0] epc_out,
  output logic        exc_mem_req,
  output logic [31:0] exc_mem_addr,
  output logic        exc_busy,
  output logic        bad_target
);

  // Last EXC_WAIT count value; EXC_WAIT is never entered when MEM_LAT is 1.
  localparam logic [1:0] WaitLast = 2'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);

  exc_state_t  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] vec_q, vec_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        bad_q, bad_d;
  logic [31:0] mux_pc;
  logic        mux_reserved;
  logic [1:0]  cause;
  logic        load;

  pc_next_mux u_pc_next_mux (
    .pc_src_i      (pc_src),
    .alu_result_i  (alu_result),
    .alu_out_i     (alu_out),
    .jump_target_i (jump_target),
    .rs_data_i     (rs_data),
    .epc_i         (epc_q),
    .pc_next_o     (mux_pc),
    .reserved_o    (mux_reserved)
  );

  assign cause = exc_cause(exc_opcode, exc_overflow, exc_div0);
  assign load  = (pc_write | (pc_write_cond & cond_met)) & ~mux_reserved;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    bad_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cause != EXC_NONE) begin
          // PC was already advanced at fetch, so the faulting instruction is at PC-4.
          epc_d   = pc_q - 32'd4;
          state_d = StExcReq;
          unique case (cause)
            EXC_OPC: vec_d = VEC_OPC;
            EXC_OVF: vec_d = VEC_OVF;
            default: vec_d = VEC_DIV0;
          endcase
        end else if (load) begin
          pc_d  = mux_pc;
          bad_d = |mux_pc[1:0];
        end
      end
      StExcReq: begin
        cnt_d   = '0;
        state_d = (MEM_LAT > 1) ? StExcWait : StExcLoad;
      end
      StExcWait: begin
        if (cnt_q == WaitLast) begin
          state_d = StExcLoad;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      StExcLoad: begin
        pc_d    = {24'b0, mem_byte};
        bad_d   = |mem_byte[1:0];
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      epc_q   <= '0;
      vec_q   <= '0;
      cnt_q   <= '0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      bad_q   <= bad_d;
    end
  end

  assign pc_out       = pc_q;
  assign epc_out      = epc_q;
  assign exc_mem_req  = (state_q == StExcReq) || (state_q == StExcWait);
  assign exc_mem_addr = exc_mem_req ? vec_q : '0;
  assign exc_busy     = (state_q != StIdle);
  assign bad_target   = bad_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit: expected PC values are queued as stimulus is driven
// and popped when the corresponding edge has happened.
module tb_pc_next_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned MEM_LAT  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_write, pc_write_cond, cond_met;
  logic [2:0]  pc_src;
  logic [31:0] alu_result, alu_out, jump_target, rs_data;
  logic        exc_opcode, exc_overflow, exc_div0;
  logic [7:0]  mem_byte;
  logic [31:0] pc_out, epc_out, exc_mem_addr;
  logic        exc_mem_req, exc_busy, bad_target;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [31:0] exp_pc_q[$];

  always #5 clk = ~clk;

  pc_next_unit #(
    .RESET_PC (RESET_PC),
    .MEM_LAT  (MEM_LAT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .cond_met      (cond_met),
    .pc_src        (pc_src),
    .alu_result    (alu_result),
    .alu_out       (alu_out),
    .jump_target   (jump_target),
    .rs_data       (rs_data),
    .exc_opcode    (exc_opcode),
    .exc_overflow  (exc_overflow),
    .exc_div0      (exc_div0),
    .mem_byte      (mem_byte),
    .pc_out        (pc_out),
    .epc_out       (epc_out),
    .exc_mem_req   (exc_mem_req),
    .exc_mem_addr  (exc_mem_addr),
    .exc_busy      (exc_busy),
    .bad_target    (bad_target)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pc_write = 0; pc_write_cond = 0; cond_met = 0; pc_src = 3'd0;
    exc_opcode = 0; exc_overflow = 0; exc_div0 = 0;
  endtask

  // Loads a PC value through pc_src=0 in one cycle, no checking.
  task automatic set_pc(input logic [31:0] v);
    pc_write = 1; pc_src = 3'd0; alu_result = v;
    tick();
    pc_write = 0;
  endtask

  task automatic test_reset();
    logic [31:0] e;
    reset = 1; idle_inputs();
    alu_result = 32'd4; alu_out = 0; jump_target = 0; rs_data = 0; mem_byte = 0;
    pc_write = 1;
    exp_pc_q.push_back(RESET_PC);
    tick(); tick();
    e = exp_pc_q.pop_front();
    n_cmp++; if (pc_out !== e) begin n_err++; $display("FAIL reset_pc got %h want %h", pc_out, e); end
    n_cmp++; if (epc_out !== 32'd0) begin n_err++; $display("FAIL reset_epc got %h want 0", epc_out); end
    n_cmp++;
    if ({exc_mem_req, exc_busy, bad_target} !== 3'b000 || exc_mem_addr !== 32'd0) begin
      n_err++;
      $display("FAIL reset_outs got req=%b busy=%b bad=%b addr=%h want all 0",
               exc_mem_req, exc_busy, bad_target, exc_mem_addr);
    end
    reset = 0;
    exp_pc_q.push_back(32'd4);
    tick();
    e = exp_pc_q.pop_front();
    n_cmp++; if (pc_out !== e) begin n_err++; $display("FAIL first_load got %h want %h", pc_out, e); end
    pc_write = 0;
  endtask

  task automatic test_cond_branch();
    logic [31:0] e;
    pc_write_cond = 1; pc_src = 3'd1; alu_out = 32'h40; cond_met = 0;
    exp_pc_q.push_back(32'd4);
    tick();
    e = exp_pc_q.pop_front();
    n_cmp++; if (pc_out !== e) begin n_err++; $display("FAIL branch_not_taken got %h want %h", pc_out, e); end
    cond_met = 1;
    exp_pc_q.push_back(32'h40);
    tick();
    e = exp_pc_q.pop_front();
    n_cmp++; if (pc_out !== e) begin n_err++; $display("FAIL branch_taken got %h want %h", pc_out, e); end
    idle_inputs();
  endtask

  task automatic test_jump();
    logic [31:0] e;
    set_pc(32'h1000_0008);
    pc_write = 1; pc_src = 3'd2; jump_target = 32'h1000_0100;
    exp_pc_q.push_back(32'h1000_0100);
    tick();
    e = exp_pc_q.pop_front();
    n_cmp++; if (pc_out !== e) begin n_err++; $display("FAIL jump got %h want %h", pc_out, e); end
    n_cmp++; if (bad_target !== 1'b0) begin n_err++; $display("FAIL jump_bad_aligned got %b want 0", bad_target); end
    jump_target = 32'h1000_0102;
    exp_pc_q.push_back(32'h1000_0102);
    tick();
    e = exp_pc_q.pop_front();
    n_cmp++; if (pc_out !== e) begin n_err++; $display("FAIL jump_misaligned got %h want %h", pc_out, e); end
    n_cmp++; if (bad_target !== 1'b1) begin n_err++; $display("FAIL bad_pulse got %b want 1", bad_target); end
    pc_write = 0;
    exp_pc_q.push_back(32'h1000_0102);
    tick();
    e = exp_pc_q.pop_front();
    n_cmp++; if (bad_target !== 1'b0) begin n_err++; $display("FAIL bad_once got %b want 0", bad_target); end
    n_cmp++; if (pc_out !== e) begin n_err++; $display("FAIL pc_hold got %h want %h", pc_out, e); end
    idle_inputs();
  endtask

  task automatic test_exception();
    logic [31:0] e;
    int busy_cycles;
    set_pc(32'h20);
    exc_overflow = 1; exc_div0 = 1; pc_write = 1; pc_src = 3'd0; alu_result = 32'h24;
    mem_byte = 8'h80;
    exp_pc_q.push_back(32'h20);
    tick();
    e = exp_pc_q.pop_front();
    n_cmp++; if (pc_out !== e) begin n_err++; $display("FAIL exc_load_dropped got %h want %h", pc_out, e); end
    n_cmp++; if (epc_out !== 32'h1C) begin n_err++; $display("FAIL exc_epc got %h want 0000001c", epc_out); end
    n_cmp++;
    if (exc_mem_req !== 1'b1 || exc_mem_addr !== 32'd254) begin
      n_err++; $display("FAIL exc_vec got req=%b addr=%0d want req=1 addr=254", exc_mem_req, exc_mem_addr);
    end
    // Interfering requests while busy must be ignored.
    exc_overflow = 0; exc_div0 = 0; exc_opcode = 1; alu_result = 32'h44;
    exp_pc_q.push_back(32'h80);
    busy_cycles = 0;
    for (int i = 0; i < 10 && exc_busy === 1'b1; i++) begin
      busy_cycles++;
      if (i == int'(MEM_LAT)) idle_inputs();
      tick();
    end
    n_cmp++;
    if (busy_cycles != int'(MEM_LAT) + 1) begin
      n_err++; $display("FAIL exc_busy_len got %0d want %0d", busy_cycles, MEM_LAT + 1);
    end
    e = exp_pc_q.pop_front();
    n_cmp++; if (pc_out !== e) begin n_err++; $display("FAIL exc_handler_pc got %h want %h", pc_out, e); end
    n_cmp++; if (epc_out !== 32'h1C) begin n_err++; $display("FAIL exc_epc_kept got %h want 0000001c", epc_out); end
    idle_inputs();
  endtask

  task automatic test_rte();
    logic [31:0] e;
    pc_write = 1; pc_src = 3'd4;
    exp_pc_q.push_back(32'h1C);
    tick();
    e = exp_pc_q.pop_front();
    n_cmp++; if (pc_out !== e) begin n_err++; $display("FAIL rte got %h want %h", pc_out, e); end
    n_cmp++; if (epc_out !== 32'h1C) begin n_err++; $display("FAIL rte_epc got %h want 0000001c", epc_out); end
    pc_src = 3'd6; alu_result = 32'h500; alu_out = 32'h504; jump_target = 32'h508; rs_data = 32'h50C;
    exp_pc_q.push_back(32'h1C);
    tick();
    e = exp_pc_q.pop_front();
    n_cmp++; if (pc_out !== e) begin n_err++; $display("FAIL reserved_src got %h want %h", pc_out, e); end
    idle_inputs();
  endtask

  task automatic test_exc_wrap();
    logic [31:0] e;
    int guard;
    set_pc(32'h0);
    exc_opcode = 1; exc_overflow = 1; mem_byte = 8'h00;
    tick();
    idle_inputs();
    n_cmp++; if (epc_out !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_epc got %h want fffffffc", epc_out); end
    n_cmp++; if (exc_mem_addr !== 32'd253) begin n_err++; $display("FAIL opc_vec got %0d want 253", exc_mem_addr); end
    exp_pc_q.push_back(32'h0);
    guard = 0;
    while (exc_busy === 1'b1 && guard < 10) begin guard++; tick(); end
    e = exp_pc_q.pop_front();
    n_cmp++;
    if (exc_busy !== 1'b0 || pc_out !== e) begin
      n_err++; $display("FAIL zero_handler got busy=%b pc=%h want busy=0 pc=%h", exc_busy, pc_out, e);
    end
  endtask

  task automatic test_reset_mid_exc();
    logic [31:0] e;
    set_pc(32'h300);
    exc_div0 = 1;
    tick();
    idle_inputs();
    n_cmp++; if (exc_mem_addr !== 32'd255) begin n_err++; $display("FAIL div0_vec got %0d want 255", exc_mem_addr); end
    tick();
    n_cmp++;
    if (exc_mem_req !== 1'b1 || exc_busy !== 1'b1) begin
      n_err++; $display("FAIL wait_state got req=%b busy=%b want 1 1", exc_mem_req, exc_busy);
    end
    reset = 1;
    exp_pc_q.push_back(RESET_PC);
    tick();
    reset = 0;
    e = exp_pc_q.pop_front();
    n_cmp++; if (pc_out !== e) begin n_err++; $display("FAIL abort_pc got %h want %h", pc_out, e); end
    n_cmp++;
    if (epc_out !== 32'd0 || exc_mem_req !== 1'b0 || exc_busy !== 1'b0 || exc_mem_addr !== 32'd0) begin
      n_err++;
      $display("FAIL abort_state got epc=%h req=%b busy=%b addr=%h want 0", epc_out, exc_mem_req,
               exc_busy, exc_mem_addr);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e, v;
    pc_write = 1; pc_src = 3'd3;
    for (int i = 0; i < 6; i++) begin
      v = $urandom() & 32'hFFFF_FFFC;
      rs_data = v;
      exp_pc_q.push_back(v);
      tick();
      e = exp_pc_q.pop_front();
      n_cmp++; if (pc_out !== e) begin n_err++; $display("FAIL b2b_%0d got %h want %h", i, pc_out, e); end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_cond_branch();
    test_jump();
    test_exception();
    test_rte();
    test_exc_wrap();
    test_reset_mid_exc();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
